apb_slave_mem: RTL and testbench

APB completer (slave) with an internal register-file memory. It sits directly downstream of the APB master bridge, on one of its two select lines: PSEL1 for addresses with bit 8 = 0, PSEL2 for bit 8 = 1. The master's PADDR[7:0] connects to this block's PADDR. It services 8-bit reads and writes with a programmable number of wait states and signals out-of-range accesses on PSLVERR.

---
 rtl/apb_slave_mem.sv | 144 ++++++++++++++
 tb/tb_apb_slave_mem.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB completer backed by a flop-based register-file memory.
// Programmable wait states; out-of-range accesses complete with PSLVERR and never touch memory.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  // state   | meaning
  // S_IDLE  | no transfer in progress, waiting for a setup phase
  // S_WAIT  | access phase, counting down wait states
  // S_READY | PREADY high for one cycle; write commits on this edge
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  // Only the index bits are kept; err_q already covers any address beyond MEM_DEPTH.
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic setup;
  logic start;
  logic enter_ready;
  logic mem_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    prdata_d    = prdata_q;
    mem_we      = 1'b0;
    start       = 1'b0;
    enter_ready = 1'b0;
    setup       = PSEL && !PENABLE;

    case (state_q)
      S_IDLE: begin
        if (setup) start = 1'b1;
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (setup) begin
          start = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d     = S_READY;
            enter_ready = 1'b1;
          end
        end
      end
      S_READY: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (setup) begin
          start = 1'b1;
        end else begin
          mem_we  = wr_q && !err_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new setup phase restarts the transfer from any state, overriding the above.
    if (start) begin
      addr_d  = PADDR[IDX_W-1:0];
      wr_d    = PWRITE;
      wdata_d = PWDATA;
      err_d   = 32'(PADDR) >= 32'(MEM_DEPTH);
      if (WAIT_CYCLES == 0) begin
        state_d     = S_READY;
        enter_ready = 1'b1;
      end else begin
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = S_WAIT;
      end
    end

    // Read data is captured on the edge that enters S_READY, using the freshly latched address.
    if (enter_ready && !wr_d) begin
      prdata_d = err_d ? '0 : mem_q[addr_d];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = (state_q == S_READY);
  assign PSLVERR = (state_q == S_READY) && err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with no wait states, one with two,
// driven from a shared APB bus and checked against hand-computed vectors.
module tb_apb_slave_mem;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] prdata0, prdata2;
  logic       pready0, pready2, pslverr0, pslverr2;

  int n_checks = 0;
  int n_fail   = 0;
  int err_viol = 0;
  int rdy_cnt2 = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2));

  always @(negedge PCLK) begin
    if ((pslverr0 && !pready0) || (pslverr2 && !pready2)) err_viol++;
    if (pready2) rdy_cnt2++;
  end

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;

  vec_t v0[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic go_idle(input int n);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (n) begin
      @(posedge PCLK); #1;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge; leaves PSEL high so transfers chain back-to-back.
  task automatic xfer(input bit sel0, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er, output int waits);
    bit got;
    got = 1'b0; waits = 0; rd = '0; er = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge PCLK);
      if (sel0 ? pready0 : pready2) begin
        got = 1'b1;
        rd  = sel0 ? prdata0 : prdata2;
        er  = sel0 ? pslverr0 : pslverr2;
      end else begin
        waits++;
      end
      @(posedge PCLK); #1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL xfer_timeout: addr 0x%0h, no PREADY within 40 cycles", a);
    end
  endtask

  logic [7:0] rd;
  logic       er;
  int         waits;
  int         cnt;

  initial begin
    v0[0] = '{1'b1, 8'h05, 8'hA5, 8'h00, 1'b0};
    v0[1] = '{1'b0, 8'h05, 8'h00, 8'hA5, 1'b0};
    v0[2] = '{1'b1, 8'h40, 8'hFF, 8'hA5, 1'b1};
    v0[3] = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1};
    v0[4] = '{1'b0, 8'h05, 8'h00, 8'hA5, 1'b0};
    v0[5] = '{1'b1, 8'h3F, 8'h5A, 8'hA5, 1'b0};
    v0[6] = '{1'b0, 8'h3F, 8'h00, 8'h5A, 1'b0};
    v0[7] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    v0[8] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};
    v0[9] = '{1'b0, 8'h3E, 8'h00, 8'h00, 1'b0};

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_pready", {pready0, pready2}, 0);
    chk("rst_pslverr", {pslverr0, pslverr2}, 0);
    chk("rst_prdata", {prdata0, prdata2}, 0);
    PRESETn = 1'b1;
    go_idle(1);

    // No wait states: every transfer is setup + one access cycle.
    for (int i = 0; i < 10; i++) begin
      xfer(1'b1, v0[i].wr, v0[i].addr, v0[i].wdata, rd, er, waits);
      chk($sformatf("w0_v%0d_prdata", i), rd, v0[i].exp_rd);
      chk($sformatf("w0_v%0d_pslverr", i), er, v0[i].exp_err);
      chk($sformatf("w0_v%0d_waits", i), waits, 0);
    end

    go_idle(1);
    PRESETn = 1'b0;
    #2;
    PRESETn = 1'b1;
    go_idle(1);

    // Two wait states: write then read back.
    xfer(1'b0, 1'b1, 8'h10, 8'h3C, rd, er, waits);
    chk("w2_wr10_waits", waits, 2);
    chk("w2_wr10_pslverr", er, 0);
    xfer(1'b0, 1'b0, 8'h10, 8'h00, rd, er, waits);
    chk("w2_rd10_waits", waits, 2);
    chk("w2_rd10_prdata", rd, 8'h3C);
    go_idle(1);

    // Abort: one access cycle, then PSEL drops in the first wait cycle.
    cnt = 0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h02; PWDATA = 8'h77;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    if (pready2) cnt++;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      if (pready2) cnt++;
      @(posedge PCLK); #1;
    end
    chk("abort_no_pready", cnt, 0);
    xfer(1'b0, 1'b0, 8'h02, 8'h00, rd, er, waits);
    chk("abort_rd02_prdata", rd, 8'h00);
    chk("abort_rd02_waits", waits, 2);
    xfer(1'b0, 1'b0, 8'h10, 8'h00, rd, er, waits);
    chk("pre_rst_rd10", rd, 8'h3C);
    go_idle(1);

    // Reset asserted mid-cycle while a write to 0x03 sits in S_WAIT.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h03; PWDATA = 8'h55;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    chk("async_rst_pready", pready2, 0);
    chk("async_rst_prdata", prdata2, 8'h00);
    chk("async_rst_pslverr", pslverr2, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    go_idle(1);
    xfer(1'b0, 1'b0, 8'h03, 8'h00, rd, er, waits);
    chk("post_rst_rd03", rd, 8'h00);
    xfer(1'b0, 1'b0, 8'h10, 8'h00, rd, er, waits);
    chk("post_rst_rd10", rd, 8'h00);
    go_idle(1);

    // Back-to-back writes then reads, no idle cycles between transfers.
    cnt = rdy_cnt2;
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 1'b1, 8'(i), 8'(8'h11 * (i + 1)), rd, er, waits);
      chk($sformatf("b2b_wr%0d_waits", i), waits, 2);
    end
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 1'b0, 8'(i), 8'h00, rd, er, waits);
      chk($sformatf("b2b_rd%0d_prdata", i), rd, 8'(8'h11 * (i + 1)));
      chk($sformatf("b2b_rd%0d_waits", i), waits, 2);
    end
    go_idle(2);
    chk("b2b_pready_pulses", rdy_cnt2 - cnt, 16);
    chk("pslverr_without_pready", err_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
